// File: rtl/sprite_line_renderer.sv
`default_nettype none
// ============================================================================
// sprite_line_renderer
// Renders up to NUM_SPRITES sprites into a double-buffered scanline buffer.
// Revision: 1.0
// ============================================================================
module sprite_line_renderer #(
    parameter int                 NUM_SPRITES = 8,
    parameter int                 SPRITE_SIZE = 32,
    parameter int                 H_ACTIVE    = 640,
    parameter int                 V_ACTIVE    = 480,
    parameter int                 V_TOTAL     = 525,
    parameter int                 COLOR_W     = 24,
    parameter logic [COLOR_W-1:0] TRANSPARENT = 24'h000000,
    localparam int                AW          = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [9:0]         VGA_HCOUNT,
    input  logic [9:0]         VGA_VCOUNT,
    input  logic               attr_we,
    input  logic [AW-1:0]      attr_addr,
    input  logic [31:0]        attr_wdata,
    output logic [4:0]         pix_id,
    output logic [9:0]         pix_addr,
    input  logic [COLOR_W-1:0] pix_data,
    output logic [7:0]         VGA_R,
    output logic [7:0]         VGA_G,
    output logic [7:0]         VGA_B,
    output logic               render_busy,
    output logic               render_overrun
);

    localparam int SW = $clog2(SPRITE_SIZE);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_FETCH = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t             r_state, w_state_nxt;

    logic               r_sh_en [NUM_SPRITES];
    logic [4:0]         r_sh_id [NUM_SPRITES];
    logic [9:0]         r_sh_x  [NUM_SPRITES];
    logic [9:0]         r_sh_y  [NUM_SPRITES];
    logic               r_ac_en [NUM_SPRITES];
    logic [4:0]         r_ac_id [NUM_SPRITES];
    logic [9:0]         r_ac_x  [NUM_SPRITES];
    logic [9:0]         r_ac_y  [NUM_SPRITES];

    logic [COLOR_W-1:0] r_lbuf [2][H_ACTIVE];
    logic               r_sel;
    logic [1:0]         r_prime;
    logic [9:0]         r_vcount_q;
    logic [AW-1:0]      r_idx;
    logic [SW-1:0]      r_col;
    logic [SW-1:0]      r_row;
    logic [10:0]        r_line;
    logic [4:0]         r_cur_id;
    logic [10:0]        r_cur_x;
    logic               r_wr_pend;
    logic [10:0]        r_wr_x;
    logic               r_overrun;
    logic [COLOR_W-1:0] r_pix;

    logic               w_line_start;
    logic               w_commit;
    logic [10:0]        w_next_line;
    logic [10:0]        w_sel_y;
    logic [10:0]        w_row_full;
    logic               w_hit;
    logic               w_last_idx;
    logic               w_wr_en;
    logic               w_disp;
    logic               w_unused;

    assign w_line_start = (VGA_VCOUNT != r_vcount_q);
    assign w_commit     = w_line_start && (VGA_VCOUNT == 10'(V_ACTIVE));
    assign w_next_line  = (VGA_VCOUNT == 10'(V_TOTAL - 1)) ? 11'd0 : {1'b0, VGA_VCOUNT} + 11'd1;
    assign w_sel_y      = {1'b0, r_ac_y[r_idx]};
    assign w_row_full   = r_line - w_sel_y;
    // 11-bit compare keeps y+SPRITE_SIZE-1 from wrapping near the top of the range
    assign w_hit        = r_ac_en[r_idx] && (r_line >= w_sel_y)
                          && (r_line <= w_sel_y + 11'(SPRITE_SIZE - 1));
    assign w_last_idx   = (r_idx == '0);
    assign w_wr_en      = r_wr_pend && !w_line_start && (pix_data != TRANSPARENT)
                          && (r_wr_x < 11'(H_ACTIVE));
    assign w_disp       = (VGA_HCOUNT < 10'(H_ACTIVE));
    assign w_unused     = ^{attr_wdata[30:29], attr_wdata[23:20], w_row_full[10:SW]};

    assign render_busy    = (r_state != ST_IDLE);
    assign render_overrun = r_overrun;
    assign pix_id         = (r_state == ST_FETCH) ? r_cur_id : 5'd0;
    assign pix_addr       = (r_state == ST_FETCH) ? 10'({r_row, r_col}) : 10'd0;
    assign VGA_R          = r_pix[COLOR_W-1 -: 8];
    assign VGA_G          = r_pix[COLOR_W-9 -: 8];
    assign VGA_B          = r_pix[COLOR_W-17 -: 8];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_SCAN: begin
                if (w_hit)           w_state_nxt = ST_FETCH;
                else if (w_last_idx) w_state_nxt = ST_IDLE;
            end
            ST_FETCH: begin
                if (&r_col) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                w_state_nxt = w_last_idx ? ST_IDLE : ST_SCAN;
            end
            default: ;
        endcase
        if (w_line_start) w_state_nxt = ST_SCAN;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_sel      <= 1'b0;
            r_prime    <= 2'd0;
            r_vcount_q <= VGA_VCOUNT;
            r_idx      <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_line     <= 11'd0;
            r_cur_id   <= 5'd0;
            r_cur_x    <= 11'd0;
            r_wr_pend  <= 1'b0;
            r_wr_x     <= 11'd0;
            r_overrun  <= 1'b0;
            r_pix      <= '0;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                r_sh_en[i] <= 1'b0;
                r_sh_id[i] <= 5'd0;
                r_sh_x[i]  <= 10'd0;
                r_sh_y[i]  <= 10'd0;
                r_ac_en[i] <= 1'b0;
                r_ac_id[i] <= 5'd0;
                r_ac_x[i]  <= 10'd0;
                r_ac_y[i]  <= 10'd0;
            end
        end else begin
            r_state    <= w_state_nxt;
            r_vcount_q <= VGA_VCOUNT;
            r_wr_pend  <= (r_state == ST_FETCH) && !w_line_start;
            r_wr_x     <= r_cur_x + 11'(r_col);

            // Commit reads the pre-write shadow, so a same-cycle write waits a frame
            for (int i = 0; i < NUM_SPRITES; i++) begin
                if (attr_we && attr_addr == AW'(i)) begin
                    r_sh_en[i] <= attr_wdata[31];
                    r_sh_id[i] <= attr_wdata[28:24];
                    r_sh_x[i]  <= attr_wdata[19:10];
                    r_sh_y[i]  <= attr_wdata[9:0];
                end
                if (w_commit) begin
                    r_ac_en[i] <= r_sh_en[i];
                    r_ac_id[i] <= r_sh_id[i];
                    r_ac_x[i]  <= r_sh_x[i];
                    r_ac_y[i]  <= r_sh_y[i];
                end
            end

            case (r_state)
                ST_SCAN: begin
                    if (w_hit) begin
                        r_col    <= '0;
                        r_row    <= w_row_full[SW-1:0];
                        r_cur_id <= r_ac_id[r_idx];
                        r_cur_x  <= {1'b0, r_ac_x[r_idx]};
                    end else if (!w_last_idx) begin
                        r_idx <= r_idx - 1'b1;
                    end
                end
                ST_FETCH: r_col <= r_col + 1'b1;
                ST_DRAIN: if (!w_last_idx) r_idx <= r_idx - 1'b1;
                default: ;
            endcase

            if (w_line_start) begin
                r_sel  <= ~r_sel;
                r_line <= w_next_line;
                r_idx  <= AW'(NUM_SPRITES - 1);
                if (r_prime != 2'd2)      r_prime   <= r_prime + 2'd1;
                if (r_state != ST_IDLE)   r_overrun <= 1'b1;
            end

            if (w_disp && r_prime == 2'd2) r_pix <= r_lbuf[r_sel][VGA_HCOUNT];
            else                           r_pix <= '0;
        end
    end

    // Buffers are wiped on reset so no pre-reset pixels surface afterwards
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int b = 0; b < 2; b++)
                for (int h = 0; h < H_ACTIVE; h++)
                    r_lbuf[b][h] <= TRANSPARENT;
        end else begin
            if (w_disp)  r_lbuf[r_sel][VGA_HCOUNT]   <= TRANSPARENT;
            if (w_wr_en) r_lbuf[~r_sel][r_wr_x[9:0]] <= pix_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sprite_line_renderer.sv
`default_nettype none
// ============================================================================
// tb_sprite_line_renderer
// Directed bench: single sprite, priority, clipping, shadow commit, overrun, reset.
// Revision: 1.0
// ============================================================================
module tb_sprite_line_renderer;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  VGA_HCOUNT;
    logic [9:0]  VGA_VCOUNT;
    logic        attr_we;
    logic [2:0]  attr_addr;
    logic [31:0] attr_wdata;
    logic [4:0]  pix_id;
    logic [9:0]  pix_addr;
    logic [23:0] pix_data = 24'h0;
    logic [7:0]  VGA_R, VGA_G, VGA_B;
    logic        render_busy;
    logic        render_overrun;

    int          errors = 0;
    int          checks = 0;
    logic [23:0] line_out [640];

    always #5 clk = ~clk;

    sprite_line_renderer dut (
        .clk            (clk),
        .reset          (reset),
        .VGA_HCOUNT     (VGA_HCOUNT),
        .VGA_VCOUNT     (VGA_VCOUNT),
        .attr_we        (attr_we),
        .attr_addr      (attr_addr),
        .attr_wdata     (attr_wdata),
        .pix_id         (pix_id),
        .pix_addr       (pix_addr),
        .pix_data       (pix_data),
        .VGA_R          (VGA_R),
        .VGA_G          (VGA_G),
        .VGA_B          (VGA_B),
        .render_busy    (render_busy),
        .render_overrun (render_overrun)
    );

    function automatic logic [23:0] mem_fn(input logic [4:0] id, input logic [9:0] addr);
        case (id)
            5'd1:    return 24'h0000FF;
            5'd2:    return 24'hFF0000;
            5'd3:    return 24'h00FF00;
            5'd4:    return addr[0] ? 24'h000000 : 24'h123456;
            5'd5:    return 24'h808080;
            default: return 24'h000000;
        endcase
    endfunction

    // Sprite memory with one clock of read latency
    always @(posedge clk) pix_data <= mem_fn(pix_id, pix_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr_attr(input int idx, input bit en, input int id, input int x, input int y);
        @(negedge clk);
        attr_we    = 1'b1;
        attr_addr  = idx[2:0];
        attr_wdata = {en, 2'b00, id[4:0], 4'b0000, x[9:0], y[9:0]};
        @(negedge clk);
        attr_we    = 1'b0;
    endtask

    task automatic new_line(input int v);
        @(negedge clk);
        VGA_HCOUNT = 10'd700;
        VGA_VCOUNT = v[9:0];
    endtask

    task automatic sweep();
        for (int h = 0; h < 640; h++) begin
            @(negedge clk);
            if (h > 0) line_out[h-1] = {VGA_R, VGA_G, VGA_B};
            VGA_HCOUNT = h[9:0];
        end
        @(negedge clk);
        line_out[639] = {VGA_R, VGA_G, VGA_B};
        VGA_HCOUNT = 10'd700;
    endtask

    task automatic do_line(input int v);
        new_line(v);
        tick(300);
        sweep();
    endtask

    initial begin
        logic [23:0] acc;
        reset      = 1'b0;
        VGA_HCOUNT = 10'd700;
        VGA_VCOUNT = 10'd0;
        attr_we    = 1'b0;
        attr_addr  = 3'd0;
        attr_wdata = 32'd0;
        tick(3);
        chk("rst_rgb",     {8'h0, VGA_R, VGA_G, VGA_B}, 32'h0);
        chk("rst_busy",    render_busy, 0);
        chk("rst_overrun", render_overrun, 0);
        chk("rst_pix_id",  pix_id, 0);
        chk("rst_pix_addr", pix_addr, 0);
        @(negedge clk);
        reset = 1'b1;
        tick(2);

        // Single sprite: id1 (blue) at x=100, y=50
        wr_attr(0, 1, 1, 100, 50);
        do_line(480);
        do_line(49);
        chk("single_l49_c100", line_out[100], 24'h0);
        new_line(50);
        tick(1);
        chk("single_busy", render_busy, 1);
        tick(299);
        sweep();
        chk("single_l50_c99",  line_out[99],  24'h0);
        chk("single_l50_c100", line_out[100], 24'h0000FF);
        chk("single_l50_c131", line_out[131], 24'h0000FF);
        chk("single_l50_c132", line_out[132], 24'h0);
        do_line(80);
        do_line(81);
        chk("single_l81_c131", line_out[131], 24'h0000FF);
        do_line(82);
        chk("single_l82_c100", line_out[100], 24'h0);
        chk("single_overrun",  render_overrun, 0);

        // Priority: sprite 0 red at (10,10) over sprite 1 green at (20,10)
        wr_attr(0, 1, 2, 10, 10);
        wr_attr(1, 1, 3, 20, 10);
        do_line(480);
        do_line(9);
        do_line(10);
        chk("prio_c9",  line_out[9],  24'h0);
        chk("prio_c10", line_out[10], 24'hFF0000);
        chk("prio_c20", line_out[20], 24'hFF0000);
        chk("prio_c41", line_out[41], 24'hFF0000);
        chk("prio_c42", line_out[42], 24'h00FF00);
        chk("prio_c51", line_out[51], 24'h00FF00);
        chk("prio_c52", line_out[52], 24'h0);
        do_line(40);
        do_line(41);
        chk("prio_l41_c30", line_out[30], 24'hFF0000);
        do_line(42);
        chk("prio_l42_c30", line_out[30], 24'h0);

        // Transparency and right-edge clipping: sprite at x=620, odd columns transparent
        wr_attr(0, 0, 0, 0, 0);
        wr_attr(1, 0, 0, 0, 0);
        wr_attr(2, 1, 4, 620, 200);
        do_line(480);
        do_line(199);
        do_line(200);
        chk("clip_c619", line_out[619], 24'h0);
        chk("clip_c620", line_out[620], 24'h123456);
        chk("clip_c621", line_out[621], 24'h0);
        chk("clip_c638", line_out[638], 24'h123456);
        chk("clip_c639", line_out[639], 24'h0);
        acc = 24'h0;
        for (int h = 0; h < 16; h++) acc = acc | line_out[h];
        chk("clip_nowrap", acc, 24'h0);

        // Shadow commit: write at line 200 is invisible until vblank
        wr_attr(0, 1, 1, 300, 100);
        do_line(99);
        do_line(100);
        chk("shadow_pre_c300", line_out[300], 24'h0);
        @(negedge clk);
        VGA_HCOUNT = 10'd700;
        VGA_VCOUNT = 10'd480;
        attr_we    = 1'b1;
        attr_addr  = 3'd3;
        attr_wdata = {1'b1, 2'b00, 5'd5, 4'b0000, 10'd400, 10'd100};
        @(negedge clk);
        attr_we    = 1'b0;
        tick(300);
        sweep();
        do_line(99);
        do_line(100);
        chk("shadow_post_c300", line_out[300], 24'h0000FF);
        chk("shadow_defer_c400", line_out[400], 24'h0);
        do_line(480);
        do_line(99);
        do_line(100);
        chk("shadow_next_c400", line_out[400], 24'h808080);
        chk("shadow_next_c300", line_out[300], 24'h0000FF);

        // Overrun: eight blue sprites on lines 0..31, line advanced after 100 clk
        for (int k = 0; k < 8; k++) wr_attr(k, 1, 1, 40 * k, 0);
        do_line(480);
        chk("ovr_before", render_overrun, 0);
        new_line(4);
        tick(100);
        new_line(5);
        tick(1);
        chk("ovr_set", render_overrun, 1);
        sweep();
        chk("ovr_l5_c280", line_out[280], 24'h0000FF);
        chk("ovr_l5_c311", line_out[311], 24'h0000FF);
        chk("ovr_l5_c240", line_out[240], 24'h0000FF);
        chk("ovr_l5_c120", line_out[120], 24'h0);
        chk("ovr_l5_c0",   line_out[0],   24'h0);
        do_line(6);
        chk("ovr_l6_c0",   line_out[0],   24'h0000FF);
        chk("ovr_l6_c120", line_out[120], 24'h0000FF);
        chk("ovr_sticky",  render_overrun, 1);

        // Reset in the middle of a fetch
        new_line(7);
        tick(10);
        chk("mid_busy",   render_busy, 1);
        chk("mid_pix_id", pix_id, 1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("rst2_rgb",      {8'h0, VGA_R, VGA_G, VGA_B}, 32'h0);
        chk("rst2_busy",     render_busy, 0);
        chk("rst2_overrun",  render_overrun, 0);
        chk("rst2_pix_id",   pix_id, 0);
        chk("rst2_pix_addr", pix_addr, 0);
        do_line(8);
        chk("rst2_l8_c0", line_out[0], 24'h0);
        do_line(9);
        chk("rst2_l9_c0",   line_out[0],   24'h0);
        chk("rst2_l9_c280", line_out[280], 24'h0);
        wr_attr(0, 1, 1, 0, 0);
        do_line(480);
        do_line(10);
        do_line(11);
        chk("rst2_l11_c0",  line_out[0],  24'h0000FF);
        chk("rst2_l11_c32", line_out[32], 24'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sprite_line_renderer.md
Name: sprite_line_renderer

Overview:
- Parametrised successor to the three-sprite fixed-position controller.
- Holds an attribute table of NUM_SPRITES sprites that software can write. Each sprite has an enable bit, an image id and an x/y position.
- Renders the next scanline into a double-buffered line buffer while the current line is displayed.
- Sprite pixels are read from an external sprite pixel memory with 1-cycle latency. The block sits between the Avalon register file and the VGA output stage.

Parameters:
- NUM_SPRITES, 8, number of attribute entries (1..16).
- SPRITE_SIZE, 32, sprite width and height in pixels (power of 2).
- H_ACTIVE, 640, visible pixels per line.
- V_ACTIVE, 480, visible lines.
- V_TOTAL, 525, total lines per frame.
- COLOR_W, 24, pixel width as {R,G,B}.
- TRANSPARENT, 24'h000000, pixel value that is never written to the line buffer.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- VGA_HCOUNT  in  10  current pixel column; advances at most once per clk
- VGA_VCOUNT  in  10  current line
- attr_we  in  1  attribute write strobe
- attr_addr  in  $clog2(NUM_SPRITES)  sprite index
- attr_wdata  in  32  bit [31] enable; [28:24] id; [19:10] x; [9:0] y
- pix_id  out  5  image id presented to the sprite memory
- pix_addr  out  10  row*SPRITE_SIZE+col within the image
- pix_data  in  COLOR_W  pixel data, valid the clk after pix_id/pix_addr
- VGA_R, VGA_G, VGA_B  out  8 each  output colour
- render_busy  out  1  high while the FSM is not IDLE
- render_overrun  out  1  sticky; cleared only by reset

Behaviour:
- Reset (reset==0 sampled at a clk edge):
  - Both attribute tables cleared (all sprites disabled).
  - FSM goes to IDLE; buffer select=0; prime counter=0.
  - render_overrun=0, render_busy=0, pix_id=0, pix_addr=0, VGA_R/G/B=0.
- Attribute tables:
  - attr_we writes the shadow table.
  - The shadow table is copied to the active table in one cycle on the clk where VGA_VCOUNT changes to V_ACTIVE (start of vblank).
  - The renderer reads only the active table, so there is no mid-frame tearing.
- Line start: any clk where VGA_VCOUNT differs from its registered copy. On line start:
  - Swap front/back buffers.
  - next_line = (VGA_VCOUNT==V_TOTAL-1) ? 0 : VGA_VCOUNT+1.
  - FSM goes to SCAN with index=NUM_SPRITES-1.
  - Prime counter saturates at 2.
- FSM states: IDLE, SCAN, FETCH, DRAIN.
  - SCAN, 1 cycle per sprite:
    - If enabled and y <= next_line <= y+SPRITE_SIZE-1, go to FETCH with col=0 and row=next_line-y.
    - Otherwise decrement index, or go to IDLE after index 0.
  - FETCH: drive pix_id=id and pix_addr=row*SPRITE_SIZE+col; col increments each clk. After col==SPRITE_SIZE-1, go to DRAIN.
  - DRAIN: 1 cycle to capture the last pixel. Then decrement index and go to SCAN, or go to IDLE after index 0.
  - Write-back: pix_data for column c goes to back[x+c] one clk after issue. Writes with pix_data==TRANSPARENT or x+c >= H_ACTIVE are suppressed.
  - Worst-case render time is NUM_SPRITES*(SPRITE_SIZE+2) cycles.
- Priority: sprites are rendered from highest to lowest index. The lower index overwrites, so index 0 is on top.
- y arithmetic uses 11 bits, so y+SPRITE_SIZE does not wrap. Sprites with y >= V_TOTAL never match.
- Display and clear-behind:
  - Each clk with VGA_HCOUNT < H_ACTIVE, front[VGA_HCOUNT] is registered to VGA_R/G/B, so output latency is 1 clk.
  - In the same clk, front[VGA_HCOUNT] is written to TRANSPARENT, so the buffer is clean when it next becomes back.
  - For VGA_HCOUNT >= H_ACTIVE, outputs are 0.
  - Outputs are forced to 0 until the prime counter reaches 2.
- Overrun: if a line start occurs while not IDLE:
  - Set render_overrun.
  - Abort the current render (pixels already written remain).
  - Perform the normal swap and restart at SCAN.
  - A pending DRAIN write is discarded.
- Simultaneous attr_we and table commit on the same clk: the commit copies the pre-write shadow contents; the new write lands in shadow and commits at the next vblank.
- Reset mid-render: FSM aborts immediately; no further writes occur.

Test Plan:
- Single sprite: sprite 0 enabled, id 1, x=100, y=50; memory returns pixel 24'h0000FF for all addresses; run 2 frames. Line 50..81, columns 100..131 show B=FF one clk after hcount; line 82 is all zero; render_overrun=0.
- Priority and overlap: sprite 0 at (10,10) returns 24'hFF0000; sprite 1 at (20,10) returns 24'h00FF00. Columns 20..41 are red, 42..51 green; lines 10..41 only.
- Transparency and clipping: sprite at x=620 returns TRANSPARENT for odd columns. Only even columns 620..638 are non-zero; no write occurs at or beyond column 640.
- Shadow commit: write sprite 0 y=100 at vcount=200. Frame is unchanged until vcount reaches 480; the next frame shows the sprite at line 100. An attr_we on the commit clk is deferred by one frame.
- Overrun: NUM_SPRITES=8, all overlapping line 5; advance VGA_VCOUNT every 100 clk. render_overrun goes to 1 and stays 1; display still swaps each line.
- Reset: assert reset=0 for 1 clk mid-FETCH. All outputs are 0 next clk; outputs stay black until the second line start; attribute table is empty.
